// File: rtl/tone_sequencer.sv
// Note-table tone sequencer: plays {freq, len} entries as timed beats with a
// silent articulation gap after each note, driving a downstream PWM generator.
module tone_sequencer #(
  parameter int          BEAT_CYCLES = 25_000_000,
  parameter int          GAP_CYCLES  = 1_000_000,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] IDLE_FREQ   = 32'd1000,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_freq,
  input  logic [7:0]    wr_len,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [9:0]    volume,
  output logic [31:0]   freq,
  output logic [9:0]    duty,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx
);

  localparam int CW = $clog2(BEAT_CYCLES + GAP_CYCLES) + 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [7:0]    beat_cnt;

  logic [31:0]   tbl_freq [DEPTH];
  logic [7:0]    tbl_len  [DEPTH];
  logic [31:0]   ent_freq;
  logic [7:0]    ent_len;

  assign ent_freq = tbl_freq[note_idx];
  assign ent_len  = tbl_len[note_idx];

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tbl_freq[wr_addr] <= wr_freq;
      tbl_len[wr_addr]  <= wr_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      state    <= S_IDLE;
      freq     <= IDLE_FREQ;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= '0;
      cyc_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            note_idx <= '0;
            cyc_cnt  <= '0;
          end
        end

        S_LOAD: begin
          if (ent_len == 8'd0) begin
            // A looping restart from entry 0 would spin forever on an empty table
            if (loop && note_idx != '0) begin
              note_idx <= '0;
            end else begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              freq     <= IDLE_FREQ;
              duty     <= '0;
              note_idx <= '0;
            end
          end else begin
            if (ent_freq != 32'd0) begin
              freq <= ent_freq;
              duty <= volume;
            end else begin
              duty <= '0;
            end
            beat_cnt <= ent_len;
            cyc_cnt  <= '0;
            state    <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (cyc_cnt == BEAT_LAST) begin
            cyc_cnt <= '0;
            if (beat_cnt == 8'd1) begin
              state <= S_GAP;
              duty  <= '0;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cyc_cnt == GAP_LAST) begin
            cyc_cnt <= '0;
            if (note_idx == IDX_LAST) begin
              // Running off the end of the table counts as an end-of-sequence
              if (loop) begin
                note_idx <= '0;
                state    <= S_LOAD;
              end else begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                freq     <= IDLE_FREQ;
                duty     <= '0;
                note_idx <= '0;
              end
            end else begin
              note_idx <= note_idx + AW'(1);
              state    <= S_LOAD;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=4.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_freq;
  logic [7:0]  wr_len;
  logic        start;
  logic        stop;
  logic        loop;
  logic [9:0]  volume;
  logic [31:0] freq;
  logic [9:0]  duty;
  logic        busy;
  logic        done;
  logic [1:0]  note_idx;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  tone_sequencer #(
    .BEAT_CYCLES(4),
    .GAP_CYCLES (2),
    .DEPTH      (4),
    .IDLE_FREQ  (32'd1000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_freq (wr_freq),
    .wr_len  (wr_len),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .volume  (volume),
    .freq    (freq),
    .duty    (duty),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // {busy, freq, duty, done, note_idx}
  function automatic logic [45:0] snap();
    return {busy, freq, duty, done, note_idx};
  endfunction

  // Hand-derived trace of one pass over table A, cycle 1 = first cycle after start
  function automatic logic [45:0] exp_a(input int c);
    logic        b  = 1'b1;
    logic [31:0] f  = 32'd1000;
    logic [9:0]  d  = 10'd0;
    logic        dn = 1'b0;
    logic [1:0]  ix = 2'd0;
    if (c == 1)       begin f = 32'd1000; ix = 2'd0; end
    else if (c <= 9)  begin f = 32'd440; d = 10'd512; ix = 2'd0; end
    else if (c <= 11) begin f = 32'd440; ix = 2'd0; end
    else if (c <= 18) begin f = 32'd440; ix = 2'd1; end
    else if (c == 19) begin f = 32'd440; ix = 2'd2; end
    else if (c <= 23) begin f = 32'd880; d = 10'd512; ix = 2'd2; end
    else if (c <= 25) begin f = 32'd880; ix = 2'd2; end
    else if (c == 26) begin f = 32'd880; ix = 2'd3; end
    else begin b = 1'b0; f = 32'd1000; dn = (c == 27); ix = 2'd0; end
    return {b, f, d, dn, ix};
  endfunction

  task automatic write_entry(input logic [1:0] a, input logic [31:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_len = l;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic write_table_a();
    write_entry(2'd0, 32'd440, 8'd2);
    write_entry(2'd1, 32'd0,   8'd1);
    write_entry(2'd2, 32'd880, 8'd1);
    write_entry(2'd3, 32'd123, 8'd0);
  endtask

  // Leaves the bench #1 into cycle 1 (start was high during cycle 0)
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic halt();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [45:0] obs;
    reset = 1'b1; start = 1'b1; stop = 1'b0; wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    obs = snap();
    chk_cnt++;
    if (obs !== {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0})
      $display("FAIL reset_state got %h exp %h", obs, {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0});
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [45:0] obs, exp;
    write_table_a();
    volume = 10'd512; loop = 1'b0;
    pulse_start();
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      exp = exp_a(c);
      obs = snap();
      if (!exp[45]) obs[1:0] = 2'd0;
      chk_cnt++;
      if (obs !== exp) $display("FAIL sequence c=%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_loop();
    logic [45:0] obs, exp;
    volume = 10'd512; loop = 1'b1;
    pulse_start();
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c <= 26) exp = exp_a(c);
      else begin
        exp = exp_a(((c - 27) % 26) + 1);
        if (((c - 27) % 26) == 0) exp[44:13] = 32'd880;
      end
      obs = snap();
      chk_cnt++;
      if (obs !== exp) $display("FAIL loop c=%0d got %h exp %h", c, obs, exp);
      else pass_cnt++;
    end
    loop = 1'b0;
    halt();
  endtask

  task automatic test_stop();
    logic [45:0] obs;
    volume = 10'd512;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (duty !== 10'd512 || busy !== 1'b1) $display("FAIL stop_pre got duty=%0d busy=%0b exp duty=512 busy=1", duty, busy);
    else pass_cnt++;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    obs = snap();
    chk_cnt++;
    if (obs !== {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0})
      $display("FAIL stop_idle got %h exp %h", obs, {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL stop_after i=%0d got done=%0b busy=%0b exp 0/0", i, done, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_empty();
    logic [45:0] obs;
    write_entry(2'd0, 32'd500, 8'd0);
    for (int l = 0; l < 2; l++) begin
      loop = l[0];
      pulse_start();
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b1 || done !== 1'b0 || note_idx !== 2'd0)
        $display("FAIL empty_load loop=%0d got busy=%0b done=%0b idx=%0d exp 1/0/0", l, busy, done, note_idx);
      else pass_cnt++;
      @(negedge clk);
      obs = snap();
      obs[1:0] = 2'd0;
      chk_cnt++;
      if (obs !== {1'b0, 32'd1000, 10'd0, 1'b1, 2'd0})
        $display("FAIL empty_done loop=%0d got %h exp %h", l, obs, {1'b0, 32'd1000, 10'd0, 1'b1, 2'd0});
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_after loop=%0d got done=%0b busy=%0b exp 0/0", l, done, busy);
      else pass_cnt++;
    end
    loop = 1'b0;
  endtask

  task automatic test_wrap();
    logic [45:0] obs;
    for (int l = 0; l < 2; l++) begin
      write_entry(2'd0, 32'd100, 8'd1);
      write_entry(2'd1, 32'd200, 8'd1);
      write_entry(2'd2, 32'd300, 8'd1);
      write_entry(2'd3, 32'd400, 8'd1);
      volume = 10'd512; loop = l[0];
      pulse_start();
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        obs = snap();
        case (c)
          2: begin
            chk_cnt++;
            if (obs !== {1'b1, 32'd100, 10'd512, 1'b0, 2'd0}) $display("FAIL wrap loop=%0d c=2 got %h", l, obs);
            else pass_cnt++;
          end
          9: begin
            chk_cnt++;
            if (obs !== {1'b1, 32'd200, 10'd300, 1'b0, 2'd1}) $display("FAIL wrap_vol loop=%0d c=9 got %h", l, obs);
            else pass_cnt++;
          end
          23: begin
            chk_cnt++;
            if (obs !== {1'b1, 32'd400, 10'd300, 1'b0, 2'd3}) $display("FAIL wrap loop=%0d c=23 got %h", l, obs);
            else pass_cnt++;
          end
          28: begin
            chk_cnt++;
            if (obs !== {1'b1, 32'd400, 10'd0, 1'b0, 2'd3}) $display("FAIL wrap_gap loop=%0d c=28 got %h", l, obs);
            else pass_cnt++;
          end
          29: begin
            if (l == 0) obs[1:0] = 2'd0;
            chk_cnt++;
            if (l == 0 && obs !== {1'b0, 32'd1000, 10'd0, 1'b1, 2'd0}) $display("FAIL wrap_end loop=0 got %h", obs);
            else if (l == 1 && obs !== {1'b1, 32'd400, 10'd0, 1'b0, 2'd0}) $display("FAIL wrap_restart loop=1 got %h", obs);
            else pass_cnt++;
          end
          30: begin
            if (l == 0) obs[1:0] = 2'd0;
            chk_cnt++;
            if (l == 0 && obs !== {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0}) $display("FAIL wrap_idle loop=0 got %h", obs);
            else if (l == 1 && obs !== {1'b1, 32'd100, 10'd300, 1'b0, 2'd0}) $display("FAIL wrap_replay loop=1 got %h", obs);
            else pass_cnt++;
          end
          default: ;
        endcase
        if (c == 3) volume = 10'd300;
      end
      loop = 1'b0;
      halt();
    end
  endtask

  task automatic test_start_stop();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0 || freq !== 32'd1000) $display("FAIL start_stop i=%0d got busy=%0b freq=%0d exp 0/1000", i, busy, freq);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL start_stop_after got busy=%0b exp 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_gap();
    logic [45:0] obs;
    write_table_a();
    volume = 10'd512; loop = 1'b0;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b1 || duty !== 10'd0 || freq !== 32'd440)
      $display("FAIL reset_gap_pre got busy=%0b duty=%0d freq=%0d exp 1/0/440", busy, duty, freq);
    else pass_cnt++;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    obs = snap();
    chk_cnt++;
    if (obs !== {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0})
      $display("FAIL reset_gap got %h exp %h", obs, {1'b0, 32'd1000, 10'd0, 1'b0, 2'd0});
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_len = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; volume = '0;
    test_reset();
    test_sequence();
    test_loop();
    test_stop();
    test_empty();
    test_wrap();
    test_start_stop();
    test_reset_gap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 25_000_000, clk cycles per beat (0.25 s at 100 MHz); legal values >=1.
REQ-002 SHALL have parameter GAP_CYCLES, default 1_000_000, silent articulation gap after each note; legal values >=1.
REQ-003 SHALL have parameter DEPTH, default 16, note-table entries; legal values are powers of 2 from 2 to 256; AW = log2(DEPTH).
REQ-004 SHALL have parameter IDLE_FREQ, default 1000, the freq value driven whenever no note is sounding; legal values are nonzero.
REQ-005 SHALL have port clk, input, 1, clock (100 MHz).
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port wr_en, input, 1, note-table write strobe.
REQ-008 SHALL have port wr_addr, input, AW, table write address.
REQ-009 SHALL have port wr_freq, input, 32, note frequency in Hz; 0 means rest.
REQ-010 SHALL have port wr_len, input, 8, note length in beats; 0 means end-of-sequence marker.
REQ-011 SHALL have port start, input, 1, level-sampled play request.
REQ-012 SHALL have port stop, input, 1, level-sampled abort request.
REQ-013 SHALL have port loop, input, 1, repeat the sequence at its end.
REQ-014 SHALL have port volume, input, 10, duty applied to sounding notes.
REQ-015 SHALL have port freq, output, 32, frequency to the PWM generator.
REQ-016 SHALL have port duty, output, 10, duty to the PWM generator.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle end-of-sequence pulse.
REQ-019 SHALL have port note_idx, output, AW, index of the current entry.

Function
REQ-020 SHALL hold a DEPTH x (32+8) register table; a write takes effect at the clk edge where wr_en=1; writes are accepted in any state.
REQ-021 SHALL implement the states IDLE, LOAD, PLAY, GAP.
REQ-022 SHALL, in IDLE with start=1 and stop=0, go to LOAD with note_idx=0 on the next cycle; start SHALL be ignored in every other state.
REQ-023 SHALL, in LOAD with entry len=0, end the sequence: with loop=1 and note_idx!=0, set note_idx=0 and stay in LOAD; otherwise pulse done=1 for one cycle and go to IDLE.
REQ-024 SHALL, in LOAD with len!=0, register freq=entry freq (or leave freq unchanged when entry freq=0), register duty=volume (or 0 when entry freq=0), load the beat counter with len, and go to PLAY.
REQ-025 SHALL remain in PLAY for exactly len*BEAT_CYCLES cycles, using a cycle counter and a beat counter.
REQ-026 SHALL, on leaving PLAY, set duty=0, keep freq unchanged, and remain in GAP for exactly GAP_CYCLES cycles.
REQ-027 SHALL, on leaving GAP, increment note_idx and enter LOAD; if note_idx=DEPTH-1, it SHALL instead treat the wrap as an end-of-sequence and apply REQ-023.
REQ-028 SHALL sample volume and the table entry only in LOAD; changes during PLAY are not visible until the next LOAD.
REQ-029 SHALL, on stop=1 in any state, go to IDLE on the next cycle with duty=0, freq=IDLE_FREQ, note_idx=0, and no done pulse; when start and stop are both high, stop SHALL take priority.
REQ-030 SHALL never drive freq=0.
REQ-031 SHALL, in IDLE, drive freq=IDLE_FREQ and duty=0.
REQ-032 SHALL use cycle-counter width ceil(log2(BEAT_CYCLES+GAP_CYCLES))+1, with no overflow for any legal parameter value.

Reset
REQ-033 SHALL, on reset, enter IDLE with freq=IDLE_FREQ, duty=0, busy=0, done=0, note_idx=0, and both counters at 0; reset SHALL override stop, start, and wr_en; table contents are unspecified after reset.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=4)
REQ-034 SHALL cover: table {440/2, 0/1, 880/1, x/0}, volume=512, start pulse at cycle 0 -> busy from cycle 1; freq=440/duty=512 for 8 cycles, then duty=0 for 2; the rest entry gives duty=0 with freq=440 held for 4+2 cycles; then 880/512 for 4 cycles, gap 2; done pulses once; then IDLE with freq=1000.
REQ-035 SHALL cover: same table with loop=1 -> after entry 2 the sequencer returns to LOAD idx 0, done never pulses, and the pattern repeats identically.
REQ-036 SHALL cover: stop asserted mid-PLAY of entry 0 -> next cycle busy=0, duty=0, freq=1000, note_idx=0, and done stays 0.
REQ-037 SHALL cover: entry 0 len=0 with start -> one LOAD cycle, then done=1 for one cycle and busy=0; with loop=1 the result SHALL be the same, with no hang.
REQ-038 SHALL cover: all 4 entries nonzero len -> after idx 3 the wrap ends the sequence with done=1 (loop=0), or restarts at idx 0 (loop=1).
REQ-039 SHALL cover: start=stop=1 in IDLE -> the block stays in IDLE; a reset asserted mid-GAP -> all outputs match REQ-033 values on the next cycle.
